// File: rtl/alu_mdu_seq.sv
// Sequential RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide.
// Operands are latched as magnitudes; signs and division corner cases are applied in FIX.
module alu_mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            is_mdu,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] mb_q, mb_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            negp_q, negp_d;
    logic            negr_q, negr_d;
    logic            divz_q, divz_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            a_sgn_s, b_sgn_s, sa_s, sb_s, accept_s;
    logic [XLEN-1:0] ma_s, mb_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_sh_s;
    logic [XLEN+1:0] div_diff_s;
    logic [PW-1:0]   prod_s, prod_fix_s;
    logic [XLEN-1:0] fix_s;

    assign is_mdu   = (alu_op == 2'b10) && (func7 == 7'b0000001);
    assign ready    = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign accept_s = ready && start && is_mdu && !kill;

    // Operand signedness and magnitudes from the live func3 at acceptance
    always_comb begin
        a_sgn_s = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
        b_sgn_s = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
        sa_s    = a_sgn_s && a[XLEN-1];
        sb_s    = b_sgn_s && b[XLEN-1];
        ma_s    = sa_s ? (~a + XLEN'(1)) : a;
        mb_s    = sb_s ? (~b + XLEN'(1)) : b;
    end

    // One iteration of shift-add (multiplier in lo) or restoring divide (dividend in lo)
    always_comb begin
        mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : {(XLEN+1){1'b0}});
        div_sh_s   = {hi_q, lo_q[XLEN-1]};
        div_diff_s = {1'b0, div_sh_s} - {2'b00, mb_q};
    end

    // Sign fix-up and corner-case selection for the final result
    always_comb begin
        prod_s     = {hi_q, lo_q};
        prod_fix_s = negp_q ? (~prod_s + PW'(1)) : prod_s;
        fix_s      = {XLEN{1'b0}};
        if (f3_q[2] == 1'b0) begin
            if (f3_q[1:0] == 2'b00) begin
                fix_s = prod_fix_s[XLEN-1:0];
            end else begin
                fix_s = prod_fix_s[PW-1:XLEN];
            end
        end else if (f3_q[1] == 1'b0) begin
            if (divz_q) begin
                fix_s = {XLEN{1'b1}};
            end else begin
                fix_s = negp_q ? (~lo_q + XLEN'(1)) : lo_q;
            end
        end else begin
            if (divz_q) begin
                fix_s = a_q;
            end else begin
                fix_s = negr_q ? (~hi_q + XLEN'(1)) : hi_q;
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        a_d      = a_q;
        mb_d     = mb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        divz_d   = divz_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_CALC;
                    cnt_d   = {CW{1'b0}};
                    f3_d    = func3;
                    a_d     = a;
                    mb_d    = mb_s;
                    hi_d    = {XLEN{1'b0}};
                    lo_d    = ma_s;
                    negp_d  = sa_s ^ sb_s;
                    negr_d  = sa_s;
                    divz_d  = (b == {XLEN{1'b0}});
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (f3_q[2] == 1'b0) begin
                        hi_d = mul_sum_s[XLEN:1];
                        lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
                    end else if (div_diff_s[XLEN+1] == 1'b0) begin
                        hi_d = div_diff_s[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_sh_s[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_FIX: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = fix_s;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            f3_q     <= 3'b000;
            a_q      <= {XLEN{1'b0}};
            mb_q     <= {XLEN{1'b0}};
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            divz_q   <= 1'b0;
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            mb_q     <= mb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            negp_q   <= negp_d;
            negr_q   <= negr_d;
            divz_q   <= divz_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq (XLEN=32): directed corner cases plus random
// operations against an arithmetic reference model, with kill/reset/busy-start scenarios.
module tb_alu_mdu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  alu_op;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic [31:0] a_in, b_in;
    logic        kill;
    logic        is_mdu, ready, busy, done;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] last_res = 32'h0;

    alu_mdu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .func7(func7),
        .func3(func3), .a(a_in), .b(b_in), .kill(kill), .is_mdu(is_mdu),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint lx, ly;
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        lx = sx;
        ly = sy;
        case (f3)
            3'd0: begin p = {32'h0, x} * {32'h0, y}; return p[31:0]; end
            3'd1: begin p = lx * ly; return p[63:32]; end
            3'd2: begin p = lx * longint'({32'h0, y}); return p[63:32]; end
            3'd3: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'h0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                return 32'(sx / sy);
            end
            3'd5: return (y == 32'h0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 32'h0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return 32'(sx % sy);
            end
            3'd7: return (y == 32'h0) ? x : x % y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Launch one operation; optionally keep start high with changing inputs while busy.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                         input bit noisy, output logic [31:0] res, output int lat, output int bcyc);
        @(negedge clk);
        start = 1'b1; alu_op = 2'b10; func7 = 7'b0000001; func3 = f3; a_in = av; b_in = bv;
        @(negedge clk);
        start = noisy; a_in = $urandom; b_in = $urandom; func3 = 3'($urandom);
        lat = 0; bcyc = 0; res = 32'h0;
        for (int c = 1; c <= 60; c++) begin
            if (!busy) break;
            bcyc++;
            if (done) begin lat = c; res = result; end
            @(negedge clk);
            if (noisy) begin a_in = $urandom; b_in = $urandom; func3 = 3'($urandom); end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; alu_op = 2'b00; func7 = 7'h0; func3 = 3'h0;
        a_in = 32'h0; b_in = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ready, busy, done, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset: ready/busy/done/result=%b%b%b/%h want 100/00000000", ready, busy, done, result);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                  32'd2, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'h7FFFFFFC, 32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h00000000};
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 12; i++) begin
            do_op(f3s[i], as[i], bs[i], 1'b0, res, lat, bc);
            n_cmp++;
            if (res !== exp[i] || lat != 34 || bc != 34) begin
                n_fail++;
                $display("FAIL directed[%0d]: result=%h lat=%0d busy=%0d want %h/34/34", i, res, lat, bc, exp[i]);
            end
            last_res = res;
        end
    endtask

    task automatic test_random();
        logic [31:0] res, x, y;
        logic [2:0] f3;
        int lat, bc;
        for (int i = 0; i < 160; i++) begin
            f3 = 3'($urandom); x = pick_operand(); y = pick_operand();
            do_op(f3, x, y, 1'b0, res, lat, bc);
            n_cmp++;
            if (res !== ref_mdu(f3, x, y) || lat != 34) begin
                n_fail++;
                $display("FAIL random f3=%0d a=%h b=%h: result=%h lat=%0d want %h/34", f3, x, y, res, lat, ref_mdu(f3, x, y));
            end
            last_res = res;
        end
    endtask

    task automatic test_is_mdu();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            alu_op = 2'($urandom);
            func7  = ($urandom_range(0, 1) == 0) ? 7'b0000001 : 7'($urandom);
            #1;
            n_cmp++;
            if (is_mdu !== (alu_op == 2'b10 && func7 == 7'b0000001)) begin
                n_fail++;
                $display("FAIL is_mdu op=%b f7=%b: got %b", alu_op, func7, is_mdu);
            end
        end
        @(negedge clk);
        start = 1'b1; alu_op = 2'b10; func7 = 7'b0100000; func3 = 3'd0; a_in = 32'd3; b_in = 32'd4;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL non_mdu_start: ready=%b busy=%b want 1/0", ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bc;
        do_op(3'd1, 32'h89ABCDEF, 32'h76543210, 1'b1, res, lat, bc);
        n_cmp++;
        if (res !== ref_mdu(3'd1, 32'h89ABCDEF, 32'h76543210) || lat != 34 || bc != 34) begin
            n_fail++;
            $display("FAIL busy_start: result=%h lat=%0d busy=%0d want %h/34/34", res, lat, bc,
                     ref_mdu(3'd1, 32'h89ABCDEF, 32'h76543210));
        end
        n_cmp++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done: ready=%b busy=%b want 1/0", ready, busy);
        end
        last_res = res;
    endtask

    task automatic test_kill();
        int pulses;
        @(negedge clk);
        start = 1'b1; alu_op = 2'b10; func7 = 7'b0000001; func3 = 3'd0; a_in = 32'd3; b_in = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || busy !== 1'b0 || result !== last_res) begin
            n_fail++;
            $display("FAIL kill: ready=%b busy=%b result=%h want 1/0/%h", ready, busy, result, last_res);
        end
        pulses = 0;
        repeat (40) begin @(negedge clk); if (done) pulses++; end
        n_cmp++;
        if (pulses != 0 || result !== last_res) begin
            n_fail++;
            $display("FAIL kill_nodone: pulses=%0d result=%h want 0/%h", pulses, result, last_res);
        end
        start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_idle: ready=%b busy=%b want 1/0", ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic [31:0] res;
        int lat, bc;
        @(negedge clk);
        start = 1'b1; alu_op = 2'b10; func7 = 7'b0000001; func3 = 3'd4; a_in = 32'd100; b_in = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ready, busy, done, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid: ready/busy/done/result=%b%b%b/%h want 100/00000000", ready, busy, done, result);
        end
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin @(negedge clk); if (done || busy) pulses++; end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_nodone: busy/done cycles=%0d want 0", pulses);
        end
        do_op(3'd7, 32'd100, 32'd7, 1'b0, res, lat, bc);
        n_cmp++;
        if (res !== 32'd2 || lat != 34) begin
            n_fail++;
            $display("FAIL after_reset: result=%h lat=%0d want 00000002/34", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_is_mdu();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mdu_seq.md
ALU_MDU_SEQ -- requirements
Module: alu_mdu_seq

Interface
REQ-001 SHALL have parameter: XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only while ready=1.
REQ-005 SHALL have port: alu_op  input  2  main-decoder ALU class; 2'b10 = R-type.
REQ-006 SHALL have port: func7  input  7  instruction func7.
REQ-007 SHALL have port: func3  input  3  instruction func3; selects M operation.
REQ-008 SHALL have port: a, b  input  XLEN each  rs1/rs2 operands.
REQ-009 SHALL have port: kill  input  1  pipeline flush; aborts operation in flight.
REQ-010 SHALL have port: is_mdu  output  1  combinational: alu_op==2'b10 and func7==7'b0000001.
REQ-011 SHALL have port: ready  output  1  high only in IDLE.
REQ-012 SHALL have port: busy  output  1  high in CALC, FIX, DONE.
REQ-013 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-014 SHALL have port: result  output  XLEN  M-extension result.

Function
REQ-015 SHALL accept an operation on a rising edge where ready=1, start=1, is_mdu=1, kill=0; any other start SHALL be ignored.
REQ-016 SHALL latch a, b, func3 at acceptance; later input changes SHALL not affect the operation.
REQ-017 SHALL decode func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-018 SHALL implement states IDLE -> CALC -> FIX -> DONE -> IDLE; CALC lasts exactly XLEN cycles, FIX and DONE one cycle each.
REQ-019 SHALL assert done in the DONE state only, i.e. exactly XLEN+2 cycles after the accepting edge, for every operation including corner cases.
REQ-020 Multiply SHALL be radix-2 shift-add on magnitudes into a 2*XLEN product; signedness per func3 (MULH both signed, MULHSU a signed/b unsigned, MULHU none); sign applied in FIX.
REQ-021 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-022 Divide SHALL be radix-2 restoring on magnitudes; quotient sign = sign(a) xor sign(b), remainder sign = sign(a) (signed ops only), applied in FIX.
REQ-023 Divide by zero SHALL give quotient all-ones and remainder = a, no exception.
REQ-024 Signed overflow (a = -2^(XLEN-1), b = -1) SHALL give DIV = a, REM = 0.
REQ-025 Iteration counter SHALL be clog2(XLEN)+1 bits and SHALL not wrap within an operation.
REQ-026 result SHALL update only on the edge entering DONE and SHALL hold until the next DONE.
REQ-027 kill=1 in any busy state SHALL return to IDLE on the next edge with no done pulse and result unchanged; kill in IDLE SHALL block acceptance that cycle.
REQ-028 start while busy, including in the DONE cycle, SHALL be ignored; earliest next acceptance is the cycle after done.
REQ-029 is_mdu SHALL be purely combinational and independent of state.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, ready=1, busy=0, done=0, result=0, counter=0, latched operands=0, in any state including mid-operation.
REQ-031 An operation interrupted by reset SHALL produce no done pulse after rst_n returns high.

Verification (XLEN=32)
REQ-032 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 cycles after accept, busy high 34 cycles.
REQ-033 a=b=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-034 a=0xFFFFFFF9 (-7), b=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC; REMU -> 0x00000001.
REQ-035 DIVU/REMU a=0x12345678, b=0 -> 0xFFFFFFFF / 0x12345678; DIV/REM a=0x80000000, b=0xFFFFFFFF -> 0x80000000 / 0x00000000; all with 34-cycle latency.
REQ-036 kill at cycle 10 of CALC -> no done, ready=1 next cycle, result holds previous value; rst_n low at cycle 20 -> all outputs at reset values next edge, no later done.
REQ-037 start with func7=7'b0100000 -> not accepted, ready stays 1; start while busy -> ignored, first operation's result and timing unchanged.
